// File: rtl/fec_hamming_encoder_pkg.sv
// Shared types, constants and the nibble encode function for the Hamming FEC encoder.
// FEC_SECDED_EN: when defined, bit 7 of each codeword is the overall even parity (Hamming(8,4)).
package fec_hamming_encoder_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned NIBBLES_PER_MSG = 8;
    localparam int unsigned WORDS_PER_MSG   = 2;

    typedef logic [7:0] codeword_byte_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        LO,
        HI
    } fec_enc_state_t;

    function automatic codeword_byte_t hamming_encode_nibble(input logic [3:0] d);
        codeword_byte_t b;
        logic           p1;
        logic           p2;
        logic           p3;
        b  = '0;
        p1 = d[0] ^ d[1] ^ d[3];
        p2 = d[0] ^ d[2] ^ d[3];
        p3 = d[1] ^ d[2] ^ d[3];
        b[6:0] = {d[3], d[2], d[1], p3, d[0], p2, p1};
`ifdef FEC_SECDED_EN
        b[7] = ^b[6:0];
`else
        b[7] = 1'b0;
`endif
        return b;
    endfunction

endpackage

// File: rtl/fec_hamming_encoder_if.sv
// FIFO read port (upstream message buffer) and FIFO write port (downstream encoded buffer).
interface fec_hamming_encoder_if;

    logic                                          in_rd_en;
    logic [fec_hamming_encoder_pkg::DATA_WIDTH-1:0] in_rd_data;
    logic                                          in_empty;
    logic                                          out_wr_en;
    logic [fec_hamming_encoder_pkg::DATA_WIDTH-1:0] out_wr_data;
    logic                                          out_full;

    modport master (
        output in_rd_en,
        input  in_rd_data,
        input  in_empty,
        output out_wr_en,
        output out_wr_data,
        input  out_full
    );

    modport slave (
        input  in_rd_en,
        output in_rd_data,
        output in_empty,
        input  out_wr_en,
        input  out_wr_data,
        output out_full
    );

endinterface

// File: rtl/fec_hamming_encoder_nibble_enc.sv
// Combinational Hamming(7,4) / extended (8,4) encoder for one nibble.
module hamming_nibble_enc
    import fec_hamming_encoder_pkg::*;
(
    input  logic [3:0]     nibble,
    output codeword_byte_t code
);

    always_comb begin
        code = hamming_encode_nibble(nibble);
    end

endmodule

// File: rtl/fec_hamming_encoder.sv
// FEC encoder stage: pops 32-bit messages, emits two 32-bit Hamming-encoded words per message.
// Build option FEC_SECDED_EN selects extended Hamming(8,4) codewords (see package).
module fec_hamming_encoder
    import fec_hamming_encoder_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    fec_hamming_encoder_if.master  bus,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] msg_count
);

    localparam int unsigned HALF_WIDTH      = DATA_WIDTH / WORDS_PER_MSG;
    localparam int unsigned NIBBLES_PER_WRD = NIBBLES_PER_MSG / WORDS_PER_MSG;

    fec_enc_state_t         state_q;
    fec_enc_state_t         state_d;
    logic [DATA_WIDTH-1:0]  msg_q;
    logic [DATA_WIDTH-1:0]  msg_d;
    logic [COUNT_WIDTH-1:0] msg_count_q;
    logic [COUNT_WIDTH-1:0] msg_count_d;
    logic [HALF_WIDTH-1:0]  half_sel;
    logic [DATA_WIDTH-1:0]  enc_word;

    // Four encoders shared between the low and high halves, selected by state.
    always_comb begin
        half_sel = (state_q == HI) ? msg_q[DATA_WIDTH-1:HALF_WIDTH] : msg_q[HALF_WIDTH-1:0];
    end

    for (genvar k = 0; k < NIBBLES_PER_WRD; k++) begin : g_enc
        hamming_nibble_enc u_enc (
            .nibble (half_sel[4*k +: 4]),
            .code   (enc_word[8*k +: 8])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            msg_q       <= '0;
            msg_count_q <= '0;
        end else begin
            state_q     <= state_d;
            msg_q       <= msg_d;
            msg_count_q <= msg_count_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        msg_d           = msg_q;
        msg_count_d     = msg_count_q;
        bus.in_rd_en    = 1'b0;
        bus.out_wr_en   = 1'b0;
        bus.out_wr_data = '0;

        case (state_q)
            IDLE: begin
                bus.in_rd_en = !bus.in_empty;
                if (bus.in_rd_en) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                msg_d   = bus.in_rd_data;
                state_d = LO;
            end
            LO: begin
                bus.out_wr_data = enc_word;
                bus.out_wr_en   = !bus.out_full;
                if (bus.out_wr_en) begin
                    state_d = HI;
                end
            end
            HI: begin
                bus.out_wr_data = enc_word;
                bus.out_wr_en   = !bus.out_full;
                if (bus.out_wr_en) begin
                    msg_count_d = msg_count_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset masks all handshake outputs in the same cycle it is asserted.
        if (rst) begin
            bus.in_rd_en    = 1'b0;
            bus.out_wr_en   = 1'b0;
            bus.out_wr_data = '0;
        end
    end

    always_comb begin
        busy      = (state_q != IDLE) && !rst;
        msg_count = msg_count_q;
    end

endmodule

// File: tb/tb_fec_hamming_encoder.sv
// Directed and streamed checks of fec_hamming_encoder against a generator-matrix model.
module tb_fec_hamming_encoder;

    localparam int unsigned CW = 16;

`ifdef FEC_SECDED_EN
    localparam logic [7:0]  ROW [4]   = '{8'h87, 8'h99, 8'hAA, 8'h4B};
    localparam logic [31:0] SGL_LO    = 32'h0000_0087;
    localparam logic [31:0] ONES_W    = 32'hFFFF_FFFF;
    localparam logic [31:0] MIX_LO    = 32'h2D33_B44B;
    localparam logic [31:0] MIX_HI    = 32'h8799_1EAA;
`else
    localparam logic [7:0]  ROW [4]   = '{8'h07, 8'h19, 8'h2A, 8'h4B};
    localparam logic [31:0] SGL_LO    = 32'h0000_0007;
    localparam logic [31:0] ONES_W    = 32'h7F7F_7F7F;
    localparam logic [31:0] MIX_LO    = 32'h2D33_344B;
    localparam logic [31:0] MIX_HI    = 32'h0719_1E2A;
`endif
    localparam logic [31:0] SGL_HI    = 32'h4B00_0000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          busy;
    logic [CW-1:0] msg_count;

    int checks   = 0;
    int failures = 0;
    int unsigned cyc = 0;
    int viol_rd = 0;
    int viol_wr = 0;

    logic [31:0] up_q [$];
    logic [31:0] dn_q [$];
    int unsigned wr_cyc [$];
    int unsigned rd_cyc [$];

    fec_hamming_encoder_if bus ();

    fec_hamming_encoder #(.COUNT_WIDTH(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy      (busy),
        .msg_count (msg_count)
    );

    always #5 clk = ~clk;

    // Upstream FIFO (read data one cycle after pop) and downstream FIFO capture.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.in_rd_en) begin
            if (bus.in_empty || up_q.size() == 0) begin
                viol_rd <= viol_rd + 1;
            end else begin
                bus.in_rd_data <= up_q.pop_front();
                rd_cyc.push_back(cyc);
            end
        end
        bus.in_empty <= (up_q.size() == 0);
        if (bus.out_wr_en) begin
            if (bus.out_full) viol_wr <= viol_wr + 1;
            dn_q.push_back(bus.out_wr_data);
            wr_cyc.push_back(cyc);
        end
    end

    function automatic logic [31:0] model_word(input logic [31:0] msg, input bit hi);
        logic [31:0] src;
        logic [31:0] w;
        logic [7:0]  cb;
        src = hi ? (msg >> 16) : msg;
        w   = '0;
        for (int n = 0; n < 4; n++) begin
            cb = '0;
            for (int j = 0; j < 4; j++) begin
                if (src[4*n + j]) cb = cb ^ ROW[j];
            end
            w[8*n +: 8] = cb;
        end
        return w;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        bus.out_full = 1'b0;
        up_q.push_back(32'h8000_0001);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.in_rd_en, bus.out_wr_en, busy, msg_count, bus.out_wr_data} !== '0) begin
                failures++;
                $display("FAIL reset_outputs cycle=%0d rd_en=%b wr_en=%b busy=%b count=%0d data=%h expected all zero",
                         i, bus.in_rd_en, bus.out_wr_en, busy, msg_count, bus.out_wr_data);
            end
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single();
        int base;
        base = 0;
        for (int i = 0; i < 20 && dn_q.size() < base + 2; i++) @(negedge clk);
        checks++;
        if (dn_q.size() < base + 2) begin
            failures++;
            $display("FAIL single_timeout words=%0d expected 2", dn_q.size());
            return;
        end
        checks++;
        if (dn_q[base] !== SGL_LO) begin
            failures++;
            $display("FAIL single_lo got=%h expected=%h", dn_q[base], SGL_LO);
        end
        checks++;
        if (dn_q[base+1] !== SGL_HI) begin
            failures++;
            $display("FAIL single_hi got=%h expected=%h", dn_q[base+1], SGL_HI);
        end
        checks++;
        if (wr_cyc[base] !== rd_cyc[0] + 2 || wr_cyc[base+1] !== rd_cyc[0] + 3) begin
            failures++;
            $display("FAIL single_latency pop=%0d writes=%0d,%0d expected pop+2,pop+3",
                     rd_cyc[0], wr_cyc[base], wr_cyc[base+1]);
        end
        checks++;
        if (msg_count !== CW'(1) || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_count count=%0d busy=%b expected count=1 busy=0", msg_count, busy);
        end
    endtask

    task automatic test_patterns();
        logic [31:0] msgs [2];
        logic [31:0] exp_w [2];
        logic [CW-1:0] cnt0;
        int base;
        msgs  = '{32'hFFFF_FFFF, 32'h0000_0000};
        exp_w = '{ONES_W, 32'h0000_0000};
        for (int v = 0; v < 2; v++) begin
            base = dn_q.size();
            cnt0 = msg_count;
            @(posedge clk); #1;
            up_q.push_back(msgs[v]);
            for (int i = 0; i < 20 && dn_q.size() < base + 2; i++) @(negedge clk);
            checks++;
            if (dn_q.size() != base + 2) begin
                failures++;
                $display("FAIL pattern_words msg=%h words=%0d expected=%0d", msgs[v], dn_q.size() - base, 2);
                continue;
            end
            checks++;
            if (dn_q[base] !== exp_w[v] || dn_q[base+1] !== exp_w[v]) begin
                failures++;
                $display("FAIL pattern_data msg=%h got=%h,%h expected=%h,%h",
                         msgs[v], dn_q[base], dn_q[base+1], exp_w[v], exp_w[v]);
            end
            checks++;
            if (msg_count !== cnt0 + 1'b1) begin
                failures++;
                $display("FAIL pattern_count got=%0d expected=%0d", msg_count, cnt0 + 1'b1);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int nrd;
        logic [CW-1:0] cnt0;
        base = dn_q.size();
        nrd  = rd_cyc.size();
        cnt0 = msg_count;
        @(posedge clk); #1;
        up_q.push_back(32'h1234_5678);
        up_q.push_back(32'h8000_0001);
        for (int i = 0; i < 30 && dn_q.size() < base + 4; i++) @(negedge clk);
        checks++;
        if (dn_q.size() != base + 4 || rd_cyc.size() != nrd + 2) begin
            failures++;
            $display("FAIL b2b_words words=%0d pops=%0d expected 4 and 2", dn_q.size() - base, rd_cyc.size() - nrd);
            return;
        end
        checks++;
        if (dn_q[base] !== MIX_LO || dn_q[base+1] !== MIX_HI ||
            dn_q[base+2] !== SGL_LO || dn_q[base+3] !== SGL_HI) begin
            failures++;
            $display("FAIL b2b_data got=%h %h %h %h expected=%h %h %h %h",
                     dn_q[base], dn_q[base+1], dn_q[base+2], dn_q[base+3], MIX_LO, MIX_HI, SGL_LO, SGL_HI);
        end
        checks++;
        if (rd_cyc[nrd+1] !== rd_cyc[nrd] + 4 || wr_cyc[base+2] !== wr_cyc[base] + 4) begin
            failures++;
            $display("FAIL b2b_spacing pop_gap=%0d write_gap=%0d expected 4 and 4",
                     rd_cyc[nrd+1] - rd_cyc[nrd], wr_cyc[base+2] - wr_cyc[base]);
        end
        checks++;
        if (msg_count !== cnt0 + 2'd2) begin
            failures++;
            $display("FAIL b2b_count got=%0d expected=%0d", msg_count, cnt0 + 2'd2);
        end
    endtask

    task automatic test_backpressure();
        int base;
        int i;
        logic [CW-1:0] cnt0;
        base = dn_q.size();
        cnt0 = msg_count;
        @(posedge clk); #1;
        bus.out_full = 1'b1;
        up_q.push_back(32'h1234_5678);
        for (i = 0; i < 20 && bus.out_wr_data === 32'h0; i++) @(negedge clk);
        checks++;
        if (bus.out_wr_data === 32'h0) begin
            failures++;
            $display("FAIL bp_enter_lo data stayed %h expected %h", bus.out_wr_data, MIX_LO);
            bus.out_full = 1'b0;
            return;
        end
        for (int s = 0; s < 5; s++) begin
            if (s > 0) @(negedge clk);
            checks++;
            if (bus.out_wr_en !== 1'b0 || bus.out_wr_data !== MIX_LO) begin
                failures++;
                $display("FAIL bp_stall_lo cycle=%0d wr_en=%b data=%h expected wr_en=0 data=%h",
                         s, bus.out_wr_en, bus.out_wr_data, MIX_LO);
            end
        end
        @(posedge clk); #1;
        bus.out_full = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_wr_en !== 1'b1 || bus.out_wr_data !== MIX_LO) begin
            failures++;
            $display("FAIL bp_release_lo wr_en=%b data=%h expected wr_en=1 data=%h", bus.out_wr_en, bus.out_wr_data, MIX_LO);
        end
        @(posedge clk); #1;
        bus.out_full = 1'b1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            checks++;
            if (bus.out_wr_en !== 1'b0 || bus.out_wr_data !== MIX_HI) begin
                failures++;
                $display("FAIL bp_stall_hi cycle=%0d wr_en=%b data=%h expected wr_en=0 data=%h",
                         s, bus.out_wr_en, bus.out_wr_data, MIX_HI);
            end
        end
        @(posedge clk); #1;
        bus.out_full = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (dn_q.size() != base + 2) begin
            failures++;
            $display("FAIL bp_words got=%0d expected=%0d", dn_q.size() - base, 2);
        end else begin
            checks++;
            if (dn_q[base] !== MIX_LO || dn_q[base+1] !== MIX_HI) begin
                failures++;
                $display("FAIL bp_data got=%h,%h expected=%h,%h", dn_q[base], dn_q[base+1], MIX_LO, MIX_HI);
            end
        end
        checks++;
        if (msg_count !== cnt0 + 1'b1) begin
            failures++;
            $display("FAIL bp_count got=%0d expected=%0d", msg_count, cnt0 + 1'b1);
        end
    endtask

    task automatic test_reset_in_hi();
        int base;
        base = dn_q.size();
        @(posedge clk); #1;
        bus.out_full = 1'b0;
        up_q.push_back(32'h1234_5678);
        for (int i = 0; i < 20 && dn_q.size() < base + 1; i++) @(negedge clk);
        bus.out_full = 1'b1;
        checks++;
        if (dn_q.size() != base + 1 || dn_q[base] !== MIX_LO) begin
            failures++;
            $display("FAIL rsthi_low_word words=%0d expected 1 word %h", dn_q.size() - base, MIX_LO);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.out_wr_en, bus.in_rd_en, busy, bus.out_wr_data} !== '0) begin
            failures++;
            $display("FAIL rsthi_during wr_en=%b rd_en=%b busy=%b data=%h expected all zero",
                     bus.out_wr_en, bus.in_rd_en, busy, bus.out_wr_data);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.out_wr_en, busy, msg_count, bus.out_wr_data} !== '0) begin
            failures++;
            $display("FAIL rsthi_after wr_en=%b busy=%b count=%0d data=%h expected all zero",
                     bus.out_wr_en, busy, msg_count, bus.out_wr_data);
        end
        bus.out_full = 1'b0;
        repeat (6) @(negedge clk);
        checks++;
        if (dn_q.size() != base + 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rsthi_dropped words=%0d busy=%b expected 1 word busy=0", dn_q.size() - base, busy);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_q [$];
        logic [31:0] m;
        int base;
        int bad;
        base = dn_q.size();
        bad  = 0;
        @(posedge clk); #1;
        for (int n = 0; n < 1024; n++) begin
            m = $urandom();
            up_q.push_back(m);
            exp_q.push_back(model_word(m, 1'b0));
            exp_q.push_back(model_word(m, 1'b1));
        end
        for (int i = 0; i < 20000 && dn_q.size() < base + 2048; i++) begin
            @(posedge clk); #1;
            bus.out_full = ($urandom_range(0, 3) == 0);
        end
        bus.out_full = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (dn_q.size() != base + 2048) begin
            failures++;
            $display("FAIL stream_words got=%0d expected=%0d", dn_q.size() - base, 2048);
        end else begin
            for (int w = 0; w < 2048; w++) begin
                checks++;
                if (dn_q[base+w] !== exp_q[w]) begin
                    failures++;
                    bad++;
                    if (bad <= 8) $display("FAIL stream_word idx=%0d got=%h expected=%h", w, dn_q[base+w], exp_q[w]);
                end
            end
        end
        checks++;
        if (msg_count !== CW'(1024)) begin
            failures++;
            $display("FAIL stream_count got=%0d expected=%0d", msg_count, 1024);
        end
        checks++;
        if (viol_rd != 0 || viol_wr != 0) begin
            failures++;
            $display("FAIL handshake_rules rd_while_empty=%0d wr_while_full=%0d expected 0 and 0", viol_rd, viol_wr);
        end
    endtask

    initial begin
        bus.out_full = 1'b0;
        test_reset();
        test_single();
        test_patterns();
        test_back_to_back();
        test_backpressure();
        test_reset_in_hi();
        test_stream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fec_hamming_encoder.md
Name: fec_hamming_encoder

Overview:
Forward-error-correction encoder stage. Pops 32-bit message words from the upstream message buffer (FIFO read port), encodes each 4-bit nibble with a Hamming(7,4) code, optionally extended to (8,4) SECDED. Pushes the resulting 64 bits as two 32-bit encoded words into the downstream encoded-message buffer (FIFO write port). Sits between the message buffer and the modulator-side buffer.

Parameters:
DATA_WIDTH, 32, message/encoded word width; fixed at 32 (package value); 8 nibbles in, 2 words out.
COUNT_WIDTH, 16, width of completed-message counter.

Ports:
clk  in  1  clock; all logic on posedge.
rst  in  1  reset; synchronous, active-high.
in_rd_en  out  1  pop request to upstream buffer.
in_rd_data  in  32  upstream read data; valid the cycle after in_rd_en is sampled high.
in_empty  in  1  upstream buffer empty.
out_wr_en  out  1  push request to downstream buffer.
out_wr_data  out  32  encoded word.
out_full  in  1  downstream buffer full.
busy  out  1  high in any state other than IDLE.
msg_count  out  COUNT_WIDTH  number of messages fully written (both words); wraps.

Behaviour:
- Reset: state=IDLE, msg_q=0, msg_count=0, busy=0, in_rd_en=0, out_wr_en=0, out_wr_data=0. rst has priority over everything, including mid-message: a partially emitted message is dropped and not counted.
- FSM states: IDLE, WAIT, LO, HI.
- IDLE: in_rd_en = !in_empty (combinational, forced 0 while rst). If in_rd_en=1, go to WAIT; else stay in IDLE.
- WAIT: capture in_rd_data into msg_q, then go to LO. in_rd_en=0.
- LO: out_wr_data = encoded low word (nibbles 0..3, msg_q[15:0]) and out_wr_en = !out_full. If out_wr_en=1, go to HI; else hold.
- HI: out_wr_data = encoded high word (nibbles 4..7) and out_wr_en = !out_full. If out_wr_en=1, increment msg_count and go to IDLE; else hold.
- out_wr_en is never high while out_full=1. out_wr_data holds stable while stalled. Outside LO/HI, out_wr_data=0.
- Throughput: one message per 4 cycles, with no overlap between messages. Latency: in_rd_en to first out_wr_en is 2 cycles when not full.
- Nibble encoding, d[3:0] -> byte b:
  - p1=d0^d1^d3, p2=d0^d2^d3, p3=d1^d2^d3.
  - b[0]=p1, b[1]=p2, b[2]=d0, b[3]=p3, b[4]=d1, b[5]=d2, b[6]=d3.
  - b[7]=^b[6:0] with the optional feature; otherwise b[7]=0.
- Encoded word packing: nibble k maps to byte (k mod 4) of its word; low word first.
- msg_count wraps from all-ones to 0 silently.
- in_empty changing while in WAIT/LO/HI is ignored. out_full toggling mid-LO only delays the FSM; no word is duplicated or lost.

Optional Feature:
FEC_SECDED_EN
- Defined: b[7] is the overall even parity of b[6:0], giving extended Hamming(8,4) with single-error correct / double-error detect downstream.
- Undefined: b[7] is tied to 0 (plain Hamming(7,4)).
- FSM, timing and ports are identical in both builds.

Decomposition:
- Shared package gains:
  - codeword_byte_t (logic[7:0]).
  - fec_enc_state_t enum {IDLE, WAIT, LO, HI}.
  - Constants NIBBLES_PER_MSG=8 and WORDS_PER_MSG=2.
  - Function hamming_encode_nibble(logic[3:0]) returning codeword_byte_t, honouring FEC_SECDED_EN.
  - Bench tasks for filling/draining buffers, under SIMULATION.
- One natural sub-module: hamming_nibble_enc (purely combinational, 4-bit in, 8-bit out). It is instantiated 4x and muxed by state, or 8x on msg_q.

Test Plan:
- Reset: hold rst 3 cycles with in_empty=0 -> in_rd_en=0, out_wr_en=0, busy=0, msg_count=0 throughout.
- Single message 0x80000001, out_full=0 -> writes 0x00000087 then 0x4B000000 (SECDED build); msg_count=1; exactly 4 cycles IDLE->IDLE.
- 0xFFFFFFFF -> 0xFFFFFFFF, 0xFFFFFFFF with FEC_SECDED_EN; 0x7F7F7F7F, 0x7F7F7F7F without. 0x00000000 -> 0x00000000 twice in both builds.
- Backpressure: out_full=1 on entry to LO for 5 cycles, then in HI for 3 cycles -> out_wr_en=0 and out_wr_data stable while stalled; exactly 2 words written; msg_count +1.
- Stream 1024 random messages through a 1024-entry FIFO on each side -> 2048 words match a golden model in order; msg_count=1024; in_rd_en never asserted while in_empty=1.
- rst asserted in HI while out_full=1 -> next cycle state IDLE, outputs 0, msg_count=0; the dropped message's high word is never written.
